// File: rtl/sparce_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sparce_mem_arbiter_pkg
//  Description : Shared types and constants for the sparceMem request
//                arbiter. Provides the default bus widths, the memory opcode
//                and the arbiter state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package sparce_mem_arbiter_pkg;

    localparam int ADDR_WIDTH      = 32;
    localparam int DATA_WIDTH      = 32;
    localparam int DEFAULT_NUM_REQ = 3;

    typedef enum logic [0:0] {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/sparce_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sparce_mem_arbiter_if
//  Description : sparceMem request/response bus.
//                master : drives mem_valid/mem_addr/mem_wdata/mem_op,
//                         receives mem_ready/mem_rsp_valid/mem_rdata.
//                slave  : the memory side of the same bus.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sparce_mem_arbiter_if
    import sparce_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_WIDTH,
    parameter int DATA_W = DATA_WIDTH
) ();

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    mem_op_e           mem_op;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_op,
        input  mem_ready, mem_rsp_valid, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_op,
        output mem_ready, mem_rsp_valid, mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/sparce_mem_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin grant. Scans the request vector
//                starting one position after the last grant (wrapping), so
//                the most recently served requester has lowest priority.
//  Ports       : i_req        - request vector
//                i_last_grant - index of the previously granted requester
//                o_grant      - one-hot grant (all zero when no request)
//                o_grant_idx  - index of the granted requester
//                o_any        - at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [IDX_W-1:0]   i_last_grant,
    output logic      [NUM_REQ-1:0] o_grant,
    output logic      [IDX_W-1:0]   o_grant_idx,
    output logic                    o_any
);

    always_comb begin
        int               w_pos;
        logic [IDX_W-1:0] w_sel;
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_pos       = 0;
        w_sel       = '0;
        // Offset 1..NUM_REQ from last grant; offset NUM_REQ revisits the
        // last winner itself, which therefore comes last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_pos = (int'(i_last_grant) + i) % NUM_REQ;
            w_sel = IDX_W'(w_pos);
            if (!o_any && i_req[w_sel]) begin
                o_any          = 1'b1;
                o_grant[w_sel] = 1'b1;
                o_grant_idx    = w_sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sparce_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sparce_mem_arbiter
//  Description : Round-robin arbiter/sequencer sharing one sparceMem request
//                port among NUM_REQ requesters, one transaction in flight.
//                Flow: IDLE (grant+latch) -> ISSUE (mem_valid until ready)
//                -> WAIT (for mem_rsp_valid) -> RESP (one-cycle rsp_valid).
//  Ports       : clk, nrst (synchronous, active low)
//                req_valid/req_ready/req_addr/req_wdata/req_op - requesters,
//                    fields packed with requester i in slice i
//                rsp_valid/rsp_data/rsp_err - response back to the grantee
//                mem - sparceMem bus, master side
//  Options     : SPARCE_ARB_TIMEOUT_EN - when defined, WAIT gives up after
//                TIMEOUT_CYCLES cycles and answers with rsp_err=1, data 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module sparce_mem_arbiter
    import sparce_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = DEFAULT_NUM_REQ,
    parameter int ADDR_W         = ADDR_WIDTH,
    parameter int DATA_W         = DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic                          clk,
    input  wire logic                          nrst,
    input  wire logic [NUM_REQ-1:0]            req_valid,
    output logic      [NUM_REQ-1:0]            req_ready,
    input  wire logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  wire logic [NUM_REQ*DATA_W-1:0]     req_wdata,
    input  wire logic [NUM_REQ*$bits(mem_op_e)-1:0] req_op,
    output logic      [NUM_REQ-1:0]            rsp_valid,
    output logic      [DATA_W-1:0]             rsp_data,
    output logic                               rsp_err,
    sparce_mem_arbiter_if.master               mem
);

    localparam int c_idx_w = $clog2(NUM_REQ);
    localparam int c_op_w  = $bits(mem_op_e);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("sparce_mem_arbiter: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("sparce_mem_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    arb_state_e          r_state;
    arb_state_e          w_state_next;
    logic [c_idx_w-1:0]  r_last_grant;  // also the owner of the in-flight request
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    mem_op_e             r_op;
    logic [DATA_W-1:0]   r_rsp_data;

    logic [NUM_REQ-1:0]  w_grant;
    logic [c_idx_w-1:0]  w_grant_idx;
    logic                w_any;

    logic [ADDR_W-1:0]   w_addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   w_wdata_arr [NUM_REQ];
    mem_op_e             w_op_arr    [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign w_wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
        assign w_op_arr[gi]    = mem_op_e'(req_op[gi*c_op_w +: c_op_w]);
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_idx_w)
    ) u_rr_arbiter (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx),
        .o_any        (w_any)
    );

`ifdef SPARCE_ARB_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_cnt_w-1:0] r_wait_cnt;
    logic               r_rsp_err;
    logic               w_timeout;
    assign w_timeout = (r_wait_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:  if (w_any) w_state_next = ISSUE;
            // mem_rsp_valid is deliberately not looked at before WAIT.
            ISSUE: if (mem.mem_ready) w_state_next = WAIT;
            WAIT: begin
                if (mem.mem_rsp_valid) w_state_next = RESP;
`ifdef SPARCE_ARB_TIMEOUT_EN
                else if (w_timeout) w_state_next = RESP;
`endif
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state      <= IDLE;
            r_last_grant <= c_idx_w'(NUM_REQ - 1);
            r_addr       <= '0;
            r_wdata      <= '0;
            r_op         <= MEM_READ;
            r_rsp_data   <= '0;
`ifdef SPARCE_ARB_TIMEOUT_EN
            r_wait_cnt   <= '0;
            r_rsp_err    <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && w_any) begin
                r_last_grant <= w_grant_idx;
                r_addr       <= w_addr_arr[w_grant_idx];
                r_wdata      <= w_wdata_arr[w_grant_idx];
                r_op         <= w_op_arr[w_grant_idx];
            end
            if (r_state == WAIT && mem.mem_rsp_valid) begin
                // Writes carry no read data back to the requester.
                r_rsp_data <= (r_op == MEM_READ) ? mem.mem_rdata : '0;
`ifdef SPARCE_ARB_TIMEOUT_EN
                r_rsp_err  <= 1'b0;
            end else if (r_state == WAIT && w_timeout) begin
                r_rsp_data <= '0;
                r_rsp_err  <= 1'b1;
`endif
            end
`ifdef SPARCE_ARB_TIMEOUT_EN
            if (r_state == ISSUE) r_wait_cnt <= '0;
            else if (r_state == WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
`endif
        end
    end

    // Gated by nrst so every output reads zero while reset is held.
    assign req_ready = (r_state == IDLE && nrst) ? w_grant : '0;

    always_comb begin
        rsp_valid = '0;
        if (r_state == RESP) rsp_valid[r_last_grant] = 1'b1;
    end

    assign rsp_data       = r_rsp_data;
`ifdef SPARCE_ARB_TIMEOUT_EN
    assign rsp_err        = (r_state == RESP) && r_rsp_err;
`else
    assign rsp_err        = 1'b0;
`endif
    assign mem.mem_valid  = (r_state == ISSUE);
    assign mem.mem_addr   = r_addr;
    assign mem.mem_wdata  = r_wdata;
    assign mem.mem_op     = r_op;

endmodule
`default_nettype wire

// File: tb/tb_sparce_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sparce_mem_arbiter
//  Description : Directed self-checking bench for sparce_mem_arbiter with
//                three requesters; the memory side is driven by hand.
//                Optional macro SPARCE_ARB_TIMEOUT_EN selects the timeout
//                scenario (TIMEOUT_CYCLES=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sparce_mem_arbiter;
    import sparce_mem_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk;
    logic              nrst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      req_op;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              rsp_err;

    int n_asserts = 0;
    int n_fail    = 0;

    sparce_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

    sparce_mem_arbiter #(
        .NUM_REQ        (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .mem       (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_asserts++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input mem_op_e op);
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_op[i]             = op;
    endtask

    initial begin
        logic [N-1:0] exp_oh;
        int           g;

        nrst      = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_op    = '0;
        mem_if.mem_ready     = 1'b0;
        mem_if.mem_rsp_valid = 1'b0;
        mem_if.mem_rdata     = '0;
        cyc();
        cyc();

        // ---- reset state
        chk("reset req_ready", req_ready, 3'b000);
        chk("reset rsp_valid", rsp_valid, 3'b000);
        chk("reset mem_valid", mem_if.mem_valid, 1'b0);
        chk("reset mem_addr", mem_if.mem_addr, 32'h0);
        chk("reset mem_op", mem_if.mem_op, MEM_READ);
        chk("reset rsp_data", rsp_data, 32'h0);
        chk("reset rsp_err", rsp_err, 1'b0);
        nrst = 1'b1;
        cyc();

        // ---- single read from requester 1: rsp_valid 4 cycles after grant
        set_req(1, 32'h0000_1000, 32'h0, MEM_READ);
        req_valid = 3'b010;
        #1;
        chk("rd grant", req_ready, 3'b010);
        cyc();                                   // ISSUE
        req_valid = 3'b000;
        mem_if.mem_ready = 1'b1;
        #1;
        chk("rd mem_valid", mem_if.mem_valid, 1'b1);
        chk("rd mem_addr", mem_if.mem_addr, 32'h0000_1000);
        chk("rd mem_op", mem_if.mem_op, MEM_READ);
        cyc();                                   // WAIT
        mem_if.mem_ready = 1'b0;
        chk("rd wait mem_valid", mem_if.mem_valid, 1'b0);
        cyc();                                   // WAIT, memory answers
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rdata     = 32'hDEAD_BEEF;
        chk("rd early rsp_valid", rsp_valid, 3'b000);
        cyc();                                   // RESP
        mem_if.mem_rsp_valid = 1'b0;
        mem_if.mem_rdata     = '0;
        chk("rd rsp_valid", rsp_valid, 3'b010);
        chk("rd rsp_data", rsp_data, 32'hDEAD_BEEF);
        chk("rd rsp_err", rsp_err, 1'b0);
        cyc();                                   // IDLE
        chk("rd rsp_valid pulse", rsp_valid, 3'b000);
        chk("rd rsp_data hold", rsp_data, 32'hDEAD_BEEF);

        // ---- reset restores last_grant=2, then round robin of writes
        nrst = 1'b0;
        cyc();
        nrst = 1'b1;
        for (int i = 0; i < N; i++)
            set_req(i, 32'h100 * (i + 1), 32'hA0 + i, MEM_WRITE);
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            g      = k % N;
            exp_oh = 3'b001 << g;
            #1;
            chk("rr grant", req_ready, exp_oh);
            cyc();                               // ISSUE
            mem_if.mem_ready = 1'b1;
            chk("rr mem_addr", mem_if.mem_addr, 32'h100 * (g + 1));
            chk("rr mem_wdata", mem_if.mem_wdata, 32'hA0 + g);
            chk("rr mem_op", mem_if.mem_op, MEM_WRITE);
            cyc();                               // WAIT
            mem_if.mem_ready     = 1'b0;
            mem_if.mem_rsp_valid = 1'b1;
            mem_if.mem_rdata     = 32'hFFFF_FFFF; // must be ignored for writes
            cyc();                               // RESP
            mem_if.mem_rsp_valid = 1'b0;
            chk("rr rsp_valid", rsp_valid, exp_oh);
            chk("rr rsp_data", rsp_data, 32'h0);
            cyc();                               // IDLE
        end
        req_valid = 3'b000;

        // ---- backpressure: 4 cycles of mem_ready low, requester 0 wins
        set_req(0, 32'h0000_2000, 32'h55, MEM_READ);
        req_valid = 3'b101;
        #1;
        chk("bp grant", req_ready, 3'b001);
        cyc();                                   // ISSUE
        req_valid = 3'b100;
        set_req(0, 32'hBAD0_BAD0, 32'hBAD, MEM_WRITE); // must not leak
        for (int c = 0; c < 5; c++) begin
            mem_if.mem_ready = (c == 4);
            #1;
            chk("bp mem_valid", mem_if.mem_valid, 1'b1);
            chk("bp mem_addr", mem_if.mem_addr, 32'h0000_2000);
            chk("bp mem_wdata", mem_if.mem_wdata, 32'h55);
            chk("bp mem_op", mem_if.mem_op, MEM_READ);
            chk("bp no req_ready", req_ready, 3'b000);
            cyc();
        end
        mem_if.mem_ready     = 1'b0;             // WAIT
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rdata     = 32'h1234_5678;
        cyc();                                   // RESP
        mem_if.mem_rsp_valid = 1'b0;
        chk("bp rsp_valid", rsp_valid, 3'b001);
        chk("bp rsp_data", rsp_data, 32'h1234_5678);
        cyc();                                   // IDLE, requester 2 pending
        chk("bp next grant", req_ready, 3'b100);
        req_valid = 3'b000;                      // drop before grant
        #1;
        chk("bp dropped", req_ready, 3'b000);
        cyc();
        chk("bp stays idle", mem_if.mem_valid, 1'b0);

        // ---- reset while in WAIT
        set_req(1, 32'h0000_3000, 32'h0, MEM_READ);
        req_valid = 3'b010;
        cyc();                                   // ISSUE
        req_valid = 3'b000;
        mem_if.mem_ready = 1'b1;
        cyc();                                   // WAIT
        mem_if.mem_ready = 1'b0;
        nrst = 1'b0;
        cyc();                                   // reset taken
        mem_if.mem_rsp_valid = 1'b1;             // late response
        mem_if.mem_rdata     = 32'h0000_CAFE;
        #1;
        chk("rst rsp_valid", rsp_valid, 3'b000);
        chk("rst mem_valid", mem_if.mem_valid, 1'b0);
        chk("rst mem_addr", mem_if.mem_addr, 32'h0);
        chk("rst rsp_data", rsp_data, 32'h0);
        nrst = 1'b1;
        cyc();
        chk("rst late rsp ignored", rsp_valid, 3'b000);
        mem_if.mem_rsp_valid = 1'b0;
        set_req(0, 32'h0000_4000, 32'h0, MEM_READ);
        req_valid = 3'b011;
        #1;
        chk("rst req0 first", req_ready, 3'b001);
        cyc();                                   // ISSUE
        req_valid = 3'b000;
        mem_if.mem_ready = 1'b1;
        chk("rst mem_addr req0", mem_if.mem_addr, 32'h0000_4000);
        cyc();                                   // WAIT
        mem_if.mem_ready     = 1'b0;
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rdata     = 32'h0000_0077;
        cyc();                                   // RESP
        mem_if.mem_rsp_valid = 1'b0;
        chk("rst rsp req0", rsp_valid, 3'b001);
        chk("rst rsp_data req0", rsp_data, 32'h0000_0077);
        cyc();                                   // IDLE

        // ---- silent memory, requester 2
        set_req(2, 32'h0000_5000, 32'h0, MEM_READ);
        req_valid = 3'b100;
        cyc();                                   // ISSUE
        req_valid = 3'b000;
        mem_if.mem_ready = 1'b1;
        cyc();                                   // WAIT entered
        mem_if.mem_ready = 1'b0;
`ifdef SPARCE_ARB_TIMEOUT_EN
        for (int c = 0; c < 7; c++) begin
            chk("to no rsp yet", rsp_valid, 3'b000);
            cyc();
        end
        chk("to pre-edge", rsp_valid, 3'b000);
        cyc();                                   // 8 cycles after WAIT entry
        chk("to rsp_valid", rsp_valid, 3'b100);
        chk("to rsp_err", rsp_err, 1'b1);
        chk("to rsp_data", rsp_data, 32'h0);
        cyc();
        chk("to pulse end", rsp_valid, 3'b000);
`else
        for (int c = 0; c < 10; c++) begin
            chk("wait holds", rsp_valid, 3'b000);
            cyc();
        end
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rdata     = 32'h0000_0099;
        cyc();                                   // RESP
        mem_if.mem_rsp_valid = 1'b0;
        chk("late rsp_valid", rsp_valid, 3'b100);
        chk("late rsp_err", rsp_err, 1'b0);
        chk("late rsp_data", rsp_data, 32'h0000_0099);
        cyc();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sparce_mem_arbiter.md
Name: sparce_mem_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one sparceMem request port between NUM_REQ requesters.
- Accepts one request at a time and forwards it to the memory with a valid/ready handshake.
- Waits for the memory response, then routes the response data back to the requester that was granted.
- Sits between client blocks and sparceMemTop; it is the single master of the memory bus.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, sparceMemPkg::ADDR_WIDTH, address width.
- DATA_W, sparceMemPkg::DATA_WIDTH, data width.
- TIMEOUT_CYCLES, 64, response timeout; used only with SPARCE_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- nrst  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies slice i.
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_op  in  NUM_REQ*$bits(mem_op_e)  packed opcodes.
- rsp_valid  out  NUM_REQ  one-cycle response strobe to the granted requester.
- rsp_data  out  DATA_W  shared response data; valid only while a rsp_valid bit is high.
- rsp_err  out  1  timeout flag, qualified by rsp_valid.
- mem_valid  out  1  request to memory.
- mem_ready  in  1  memory accepts the request.
- mem_addr  out  ADDR_W  request address.
- mem_wdata  out  DATA_W  request write data.
- mem_op  out  mem_op_e  request opcode.
- mem_rsp_valid  in  1  memory response strobe; sent for both reads and writes.
- mem_rdata  in  DATA_W  read data; ignored for writes.

Behaviour:
- Reset (nrst=0 at a clock edge):
  - state=IDLE; all outputs 0; mem_op=MEM_READ; last_grant=NUM_REQ-1.
  - Any in-flight transaction is dropped with no response.
- State IDLE:
  - The grant g is the first requester with req_valid=1, scanning from last_grant+1 modulo NUM_REQ.
  - req_ready[g]=1 combinationally in that cycle.
  - At the edge, the arbiter latches addr/wdata/op of g, sets last_grant=g and moves to ISSUE.
  - With no req_valid, it stays in IDLE.
- State ISSUE:
  - mem_valid=1 with the latched fields held stable.
  - On mem_valid&&mem_ready it moves to WAIT; otherwise it holds (backpressure).
  - mem_rsp_valid is ignored in ISSUE; the memory never responds in the same cycle as acceptance.
- State WAIT:
  - mem_valid=0.
  - On mem_rsp_valid the arbiter registers rsp_data: mem_rdata for MEM_READ, 0 for MEM_WRITE.
  - It then moves to RESP.
- State RESP:
  - rsp_valid[g]=1 for exactly one cycle, rsp_err=0, then back to IDLE.
  - rsp_data holds its value until the next RESP.
- Minimum latency: request accepted at cycle 0, mem_valid at cycle 1, response at cycle k, rsp_valid at cycle k+1.
- Throughput: one transaction in flight, so the next grant comes at the earliest in the cycle after RESP.
- Fairness: after requester g is served, g has lowest priority. With all requesters continuously valid, grants run 0,1,2,0,...
- Requesters hold valid and fields until they see req_ready. A request dropped before grant is not remembered.
- Reset asserted in any state forces IDLE on the next edge and suppresses pending rsp_valid.

Optional Feature:
- Macro: SPARCE_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each cycle in WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without mem_rsp_valid, the arbiter goes to RESP with rsp_data=0 and rsp_err=1.
  - A late mem_rsp_valid arriving in IDLE, ISSUE or RESP is discarded.
- Undefined: no counter exists; WAIT is left only on mem_rsp_valid; rsp_err is tied to 0.

Decomposition:
- sparceMemPkg gains:
  - mem_op_e {MEM_READ, MEM_WRITE}.
  - arb_state_e {IDLE, ISSUE, WAIT, RESP}.
  - The constant DEFAULT_NUM_REQ=3.
- Sub-module rr_arbiter: parameterised NUM_REQ; combinational grant from a request vector plus last_grant; outputs a one-hot grant and its index.

Test Plan:
- Single read: req 1 valid, addr=0x0000_1000, op=MEM_READ; memory accepts at once and responds 3 cycles later with 0xDEADBEEF -> rsp_valid=3'b010 for one cycle, rsp_data=0xDEADBEEF, total 5 cycles.
- Round robin: all three requesters valid continuously, each doing writes -> grant order 0,1,2,0,1,2; each write gets rsp_valid with rsp_data=0.
- Backpressure: mem_ready low for 4 cycles -> mem_valid high, mem_addr/mem_wdata/mem_op stable for 5 cycles; no second req_ready.
- Reset mid-operation: nrst low in WAIT -> next cycle all outputs 0; a late mem_rsp_valid produces no rsp_valid; after release, requester 0 wins first.
- Timeout (SPARCE_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): memory never responds -> rsp_valid and rsp_err both 1, rsp_data=0, 8 cycles after WAIT is entered.
